// File: rtl/vx_commit_arb_if.sv
// Commit-stream bundle between the execute units and the shared writeback port.
interface vx_commit_arb_if #(
  parameter int NUM_REQS   = 6,
  parameter int DATA_WIDTH = 64
);
  localparam int SEL_WIDTH = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  logic [NUM_REQS-1:0]            valid_in;
  logic [NUM_REQS*DATA_WIDTH-1:0] data_in;
  logic [NUM_REQS-1:0]            eop_in;
  logic [NUM_REQS-1:0]            ready_in;
  logic                           valid_out;
  logic [DATA_WIDTH-1:0]          data_out;
  logic                           eop_out;
  logic [SEL_WIDTH-1:0]           sel_out;
  logic                           ready_out;

  modport slave (
    input  valid_in, data_in, eop_in, ready_out,
    output ready_in, valid_out, data_out, eop_out, sel_out
  );

  modport master (
    output valid_in, data_in, eop_in, ready_out,
    input  ready_in, valid_out, data_out, eop_out, sel_out
  );
endinterface

// File: rtl/vx_commit_arb.sv
// Round-robin commit arbiter with packet locking and a single registered
// output stage (1-cycle latency, full throughput).
module vx_commit_arb #(
  parameter int NUM_REQS   = 6,
  parameter int DATA_WIDTH = 64,
  parameter int LOCK_EOP   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_commit_arb_if.slave       bus
);
  localparam int SEL_WIDTH = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  logic [SEL_WIDTH-1:0]  ptr, lock_idx, gidx;
  logic [NUM_REQS-1:0]   grant;
  logic                  lock, en, xfer, found, beat_eop;
  logic [DATA_WIDTH-1:0] beat_data;
  int                    idx;

  assign en = !bus.valid_out || bus.ready_out;

  // Search starts just after the last winner so the previous winner is lowest priority.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    if (lock) begin
      grant[lock_idx] = 1'b1;
      gidx            = lock_idx;
    end else begin
      for (int k = 1; k <= NUM_REQS; k++) begin
        idx = (int'(ptr) + k) % NUM_REQS;
        if (!found && bus.valid_in[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gidx       = SEL_WIDTH'(idx);
        end
      end
    end
  end

  assign bus.ready_in = grant & {NUM_REQS{en}};
  assign xfer         = |(bus.valid_in & bus.ready_in);
  assign beat_data    = bus.data_in[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
  assign beat_eop     = bus.eop_in[gidx];

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.valid_out <= 1'b0;
      bus.data_out  <= '0;
      bus.eop_out   <= 1'b0;
      bus.sel_out   <= '0;
      ptr           <= SEL_WIDTH'(NUM_REQS - 1);
      lock          <= 1'b0;
      lock_idx      <= '0;
    end else if (en) begin
      if (xfer) begin
        bus.valid_out <= 1'b1;
        bus.data_out  <= beat_data;
        bus.eop_out   <= beat_eop;
        bus.sel_out   <= gidx;
        ptr           <= gidx;
        if (LOCK_EOP != 0) begin
          lock     <= !beat_eop;
          lock_idx <= gidx;
        end
      end else begin
        bus.valid_out <= 1'b0;
      end
    end
  end
endmodule
